// File: rtl/morse_seq_tx_if.sv
// Handshake and key-line bundle between a letter sequencer (master) and the
// Morse keyer (slave). MAX_LEN must match the keyer it connects to.
interface morse_seq_tx_if #(
  parameter int MAX_LEN = 4
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] code;
  logic [LEN_W-1:0]   len;
  logic               ready;
  logic               busy;
  logic               led;
  logic               done;
  logic               err;

  modport master (
    output start, abort, code, len,
    input  ready, busy, led, done, err
  );

  modport slave (
    input  start, abort, code, len,
    output ready, busy, led, done, err
  );
endinterface

// File: rtl/morse_seq_tx.sv
// Morse keyer: serialises one letter of up to MAX_LEN dot/dash symbols
// (bit0 first, 1 = dash) onto the led line. Each symbol is a mark followed
// by a space; timing is counted in units of TICK_DIV clock cycles.
// Optional feature macro: MORSE_SEQ_LETTER_GAP_EN adds an LGAP state that
// appends LGAP_UNITS of silence after the final symbol before done.
module morse_seq_tx #(
  parameter int TICK_DIV   = 25000000,
  parameter int MAX_LEN    = 4,
  parameter int DOT_UNITS  = 1,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1,
  parameter int LGAP_UNITS = 2
) (
  input  logic            CLOCK_50,
  input  logic            Resetn,
  morse_seq_tx_if.slave   tx
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int MAX_DD  = (DOT_UNITS > DASH_UNITS) ? DOT_UNITS : DASH_UNITS;
  localparam int MAX_GL  = (GAP_UNITS > LGAP_UNITS) ? GAP_UNITS : LGAP_UNITS;
  localparam int MAX_U   = (MAX_DD > MAX_GL) ? MAX_DD : MAX_GL;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int UNIT_W  = (MAX_U > 1) ? $clog2(MAX_U) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [UNIT_W-1:0]  DOT_LAST   = UNIT_W'(DOT_UNITS - 1);
  localparam logic [UNIT_W-1:0]  DASH_LAST  = UNIT_W'(DASH_UNITS - 1);
  localparam logic [UNIT_W-1:0]  GAP_LAST   = UNIT_W'(GAP_UNITS - 1);
`ifdef MORSE_SEQ_LETTER_GAP_EN
  localparam logic [UNIT_W-1:0]  LGAP_LAST  = UNIT_W'(LGAP_UNITS - 1);
`endif
  localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
`ifdef MORSE_SEQ_LETTER_GAP_EN
    , ST_LGAP = 2'd3
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [MAX_LEN-1:0]  shreg_reg;
  logic [LEN_W-1:0]    sym_cnt_reg;
  logic [PRESC_W-1:0]  presc_reg;
  logic [UNIT_W-1:0]   unit_cnt_reg;
  logic                done_reg, err_reg;
  logic                done_next, err_next;
  logic                tick, phase_end, len_ok, accept, reject;
  logic [UNIT_W-1:0]   unit_last;
  logic                led_d, ready_d;

  // State register plus the registered one-cycle done/err pulses
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state: phase length depends on state and, in MARK, on the current symbol
  always_comb begin
    tick = (presc_reg == PRESC_LAST);
    case (state_reg)
      ST_MARK: unit_last = shreg_reg[0] ? DASH_LAST : DOT_LAST;
`ifdef MORSE_SEQ_LETTER_GAP_EN
      ST_LGAP: unit_last = LGAP_LAST;
`endif
      default: unit_last = GAP_LAST;
    endcase
    phase_end = tick && (unit_cnt_reg == unit_last);
    len_ok    = (tx.len != '0) && (tx.len <= LEN_MAX);
    accept    = (state_reg == ST_IDLE) && tx.start && !tx.abort && len_ok;
    reject    = (state_reg == ST_IDLE) && tx.start && !tx.abort && !len_ok;

    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_MARK;
      end
      ST_MARK: begin
        if (tx.abort)      state_next = ST_IDLE;
        else if (phase_end) state_next = ST_SPACE;
      end
      ST_SPACE: begin
        if (tx.abort) state_next = ST_IDLE;
        else if (phase_end) begin
          if (sym_cnt_reg != '0) state_next = ST_MARK;
`ifdef MORSE_SEQ_LETTER_GAP_EN
          else                   state_next = ST_LGAP;
`else
          else                   state_next = ST_IDLE;
`endif
        end
      end
`ifdef MORSE_SEQ_LETTER_GAP_EN
      ST_LGAP: begin
        if (tx.abort || phase_end) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; done only on a normal finish
  always_comb begin
    led_d     = (state_reg == ST_MARK);
    ready_d   = (state_reg == ST_IDLE);
    done_next = (state_reg != ST_IDLE) && (state_next == ST_IDLE) && !tx.abort;
    err_next  = reject;
  end

  // Datapath: latch the letter, run the prescaler/unit counter, consume symbols
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      shreg_reg    <= '0;
      sym_cnt_reg  <= '0;
      presc_reg    <= '0;
      unit_cnt_reg <= '0;
    end else if (accept) begin
      shreg_reg    <= tx.code;
      sym_cnt_reg  <= tx.len;
      presc_reg    <= '0;
      unit_cnt_reg <= '0;
    end else if (tx.abort && (state_reg != ST_IDLE)) begin
      shreg_reg    <= '0;
      sym_cnt_reg  <= '0;
      presc_reg    <= '0;
      unit_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      // Every state is entered with both timing counters at zero
      presc_reg    <= '0;
      unit_cnt_reg <= '0;
      if (state_reg == ST_MARK) begin
        shreg_reg   <= shreg_reg >> 1;
        sym_cnt_reg <= sym_cnt_reg - 1'b1;
      end
    end else if (state_reg != ST_IDLE) begin
      if (tick) begin
        presc_reg    <= '0;
        unit_cnt_reg <= unit_cnt_reg + 1'b1;
      end else begin
        presc_reg    <= presc_reg + 1'b1;
      end
    end
  end

  assign tx.led   = led_d;
  assign tx.ready = ready_d;
  assign tx.busy  = ~ready_d;
  assign tx.done  = done_reg;
  assign tx.err   = err_reg;

endmodule

// File: tb/tb_morse_seq_tx.sv
// Bench for morse_seq_tx: a default MAX_LEN=4 keyer and a MAX_LEN=6,
// DASH_UNITS=4 keyer, both with TICK_DIV=4. Expected per-cycle outputs are
// generated from the letter and pushed to a queue when a start is driven,
// then popped and compared every cycle.
module tb_morse_seq_tx;

  localparam int TD = 4;
`ifdef MORSE_SEQ_LETTER_GAP_EN
  localparam int LG = 8;
`else
  localparam int LG = 0;
`endif

  // Observation record bits: {led, busy, ready, done, err}
  localparam logic [4:0] MARK_R  = 5'b11000;
  localparam logic [4:0] SPACE_R = 5'b01000;
  localparam logic [4:0] DONE_R  = 5'b00110;
  localparam logic [4:0] IDLE_R  = 5'b00100;
  localparam logic [4:0] ERR_R   = 5'b00101;

  logic       clk;
  logic       rst_n;
  int         sel;
  logic       start_s, abort_s;
  logic [5:0] code_s;
  logic [2:0] len_s;
  logic [4:0] obs;
  logic [4:0] exp_q[$];
  int         chk_cnt;
  int         pass_cnt;

  morse_seq_tx_if #(.MAX_LEN(4)) tx4 ();
  morse_seq_tx_if #(.MAX_LEN(6)) tx6 ();

  assign tx4.start = (sel == 0) && start_s;
  assign tx4.abort = (sel == 0) && abort_s;
  assign tx4.code  = code_s[3:0];
  assign tx4.len   = len_s;
  assign tx6.start = (sel == 1) && start_s;
  assign tx6.abort = (sel == 1) && abort_s;
  assign tx6.code  = code_s;
  assign tx6.len   = len_s;

  assign obs = (sel == 1) ? {tx6.led, tx6.busy, tx6.ready, tx6.done, tx6.err}
                          : {tx4.led, tx4.busy, tx4.ready, tx4.done, tx4.err};

  morse_seq_tx #(
    .TICK_DIV(TD), .MAX_LEN(4), .DOT_UNITS(1), .DASH_UNITS(3),
    .GAP_UNITS(1), .LGAP_UNITS(2)
  ) dut4 (
    .CLOCK_50(clk), .Resetn(rst_n), .tx(tx4)
  );

  morse_seq_tx #(
    .TICK_DIV(TD), .MAX_LEN(6), .DOT_UNITS(1), .DASH_UNITS(4),
    .GAP_UNITS(1), .LGAP_UNITS(2)
  ) dut6 (
    .CLOCK_50(clk), .Resetn(rst_n), .tx(tx6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         s;
    logic [5:0] code;
    int         len;
    int         stop;
    bit         use_rst;
    int         exp_busy;
    string      name;
  } vec_t;

  vec_t vecs[12];

  // Expected cycle-by-cycle outputs of one letter, from the timing rules
  task automatic build_exp(input int s, input logic [5:0] c, input int l);
    int dash_u;
    int max_l;
    dash_u = (s == 1) ? 4 : 3;
    max_l  = (s == 1) ? 6 : 4;
    exp_q.delete();
    if (l == 0 || l > max_l) begin
      exp_q.push_back(ERR_R);
      exp_q.push_back(IDLE_R);
    end else begin
      for (int i = 0; i < l; i++) begin
        repeat ((c[i] ? dash_u : 1) * TD) exp_q.push_back(MARK_R);
        repeat (1 * TD) exp_q.push_back(SPACE_R);
      end
      repeat (LG) exp_q.push_back(SPACE_R);
      exp_q.push_back(DONE_R);
      exp_q.push_back(IDLE_R);
    end
  endtask

  task automatic check_now(input logic [4:0] e, input string name, input int idx);
    chk_cnt++;
    if (obs === e) pass_cnt++;
    else $display("FAIL %s cyc=%0d led/busy/ready/done/err got=%b want=%b",
                  name, idx, obs, e);
  endtask

  task automatic run_letter(input vec_t v);
    logic [4:0] e;
    int idx;
    int busy_seen;
    build_exp(v.s, v.code, v.len);
    if (v.stop > 0) begin
      while (exp_q.size() > v.stop) void'(exp_q.pop_back());
      exp_q.push_back(IDLE_R);
      exp_q.push_back(IDLE_R);
    end
    @(negedge clk);
    sel = v.s; code_s = v.code; len_s = v.len[2:0]; start_s = 1'b1;
    idx = 0;
    busy_seen = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      start_s = 1'b0; abort_s = 1'b0; rst_n = 1'b1;
      check_now(e, v.name, idx);
      if (obs[3]) busy_seen++;
      if (v.stop > 0 && idx == v.stop - 1) begin
        if (v.use_rst) rst_n = 1'b0;
        else           abort_s = 1'b1;
      end
      idx++;
    end
    chk_cnt++;
    if (busy_seen == v.exp_busy) pass_cnt++;
    else $display("FAIL %s_busy_len got=%0d want=%0d", v.name, busy_seen, v.exp_busy);
    $display("letter %s code=%b len=%0d busy_cycles=%0d", v.name, v.code, v.len, busy_seen);
  endtask

  initial begin
    logic [4:0] e;
    int idx;

    vecs[0]  = '{0, 6'b000010, 2, 0,  1'b0, 24 + LG, "A"};
    vecs[1]  = '{0, 6'b000000, 0, 0,  1'b0, 0,       "len0"};
    vecs[2]  = '{0, 6'b000000, 5, 0,  1'b0, 0,       "len5"};
    vecs[3]  = '{0, 6'b000001, 1, 6,  1'b0, 6,       "T_abort"};
    vecs[4]  = '{0, 6'b000001, 1, 0,  1'b0, 16 + LG, "T_after_abort"};
    vecs[5]  = '{0, 6'b001011, 4, 0,  1'b0, 56 + LG, "four_sym"};
    vecs[6]  = '{0, 6'b001110, 1, 0,  1'b0, 8 + LG,  "dontcare_hi"};
    vecs[7]  = '{0, 6'b000010, 2, 6,  1'b1, 6,       "A_reset_space"};
    vecs[8]  = '{0, 6'b000010, 2, 0,  1'b0, 24 + LG, "A_after_reset"};
    vecs[9]  = '{1, 6'b101100, 6, 14, 1'b1, 14,      "six_reset_space"};
    vecs[10] = '{1, 6'b101100, 6, 0,  1'b0, 84 + LG, "six_sym"};
    vecs[11] = '{1, 6'b000000, 7, 0,  1'b0, 0,       "len7_max6"};

    chk_cnt = 0; pass_cnt = 0;
    sel = 0; start_s = 1'b0; abort_s = 1'b0; code_s = '0; len_s = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_now(IDLE_R, "reset_state", 0);
    sel = 1;
    #1;
    check_now(IDLE_R, "reset_state6", 0);
    sel = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check_now(IDLE_R, "post_reset_idle", 0);

    foreach (vecs[i]) run_letter(vecs[i]);

    // Back-to-back: start held across done, second letter accepted in the done cycle
    @(negedge clk);
    sel = 0; code_s = 6'd0; len_s = 3'd1; start_s = 1'b1;
    build_exp(0, 6'd0, 1);
    void'(exp_q.pop_back());
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check_now(e, "b2b_first", idx);
      if (e == DONE_R) code_s = 6'd1;
      idx++;
    end
    build_exp(0, 6'd1, 1);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check_now(e, "b2b_second", idx);
      if (idx == 0) start_s = 1'b0;
      if (idx == 3) begin start_s = 1'b1; code_s = 6'd0; len_s = 3'd2; end
      if (idx == 4) begin start_s = 1'b0; code_s = 6'd1; len_s = 3'd1; end
      idx++;
    end
    $display("letter b2b E then T held start");

    // abort in IDLE together with a valid start: nothing happens
    @(negedge clk);
    start_s = 1'b1; abort_s = 1'b1; code_s = 6'd1; len_s = 3'd1;
    @(negedge clk);
    start_s = 1'b0; abort_s = 1'b0;
    check_now(IDLE_R, "idle_abort_start", 0);
    @(negedge clk);
    check_now(IDLE_R, "idle_abort_start", 1);
    $display("letter idle abort+start ignored");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", chk_cnt, pass_cnt);
    $fatal(1, "timeout");
  end

endmodule
